updown_mode_ctrl: RTL and testbench
===================================

UPDOWN_MODE_CTRL -- requirements
Module: updown_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles before a button level is accepted (>=2).
REQ-002 Parameter TICK_DIV, 24'd5000000, clock cycles per count-enable tick (>=2).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_dir_raw  input  1  asynchronous, bouncy direction button; a press toggles the count direction.
REQ-006 btn_pause_raw  input  1  asynchronous, bouncy pause button; a press toggles between run and hold.
REQ-007 mode  output  1  direction to the downstream sync up/down counter; 1 = up, 0 = down; registered.
REQ-008 cnt_en  output  1  one-cycle count-enable tick to the downstream counter; registered.
REQ-009 paused  output  1  high while in a hold state; registered.
REQ-010 dir_changed  output  1  one-cycle pulse on the same edge that mode changes; registered.

Function
REQ-011 Each raw button SHALL pass through a 2-FF synchronizer before any other use.
REQ-012 The debounced level SHALL flip only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch gap restarts the count.
REQ-013 A press pulse (one cycle) SHALL be generated on each debounced 0->1 transition only; release generates nothing.
REQ-014 The FSM SHALL have four states: RUN_DOWN, RUN_UP, HOLD_DOWN, HOLD_UP.
REQ-015 A dir press SHALL swap UP<->DOWN and keep RUN/HOLD unchanged.
REQ-016 A pause press SHALL swap RUN<->HOLD and keep direction unchanged.
REQ-017 Simultaneous dir and pause presses in the same cycle SHALL apply both (e.g. RUN_DOWN -> HOLD_UP).
REQ-018 The state SHALL update on the edge after the press pulse; mode, paused and dir_changed SHALL reflect the new state on that same edge.
REQ-019 mode SHALL be 1 in RUN_UP/HOLD_UP and 0 otherwise; paused SHALL be 1 in HOLD_* only.
REQ-020 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; cnt_en SHALL be 1 for exactly the cycle after the prescaler reaches TICK_DIV-1 in a RUN state.
REQ-021 In HOLD states the prescaler SHALL freeze its value and cnt_en SHALL stay 0; on resume counting SHALL continue from the frozen value.
REQ-022 On any direction change the prescaler SHALL clear to 0 so the first tick in the new direction arrives a full TICK_DIV cycles later.
REQ-023 A direction change coinciding with a prescaler wrap SHALL suppress that tick.
REQ-024 dir_changed SHALL never be asserted for a pause-only press.

Reset
REQ-025 While reset is high at a rising edge: state=RUN_DOWN, mode=0, cnt_en=0, paused=0, dir_changed=0, prescaler=0, synchronizers, debounce counters and debounced levels=0.
REQ-026 Reset SHALL override any press pulse occurring in the same cycle; a button held through reset SHALL register as a press only once, after a debounced 0->1 edge seen after reset.
REQ-027 Reset mid-debounce or mid-hold SHALL discard all progress.

Structure
REQ-028 A shared package updown_ctrl_pkg SHALL hold the 2-bit state encoding constants (RUN_DOWN=00, RUN_UP=01, HOLD_DOWN=10, HOLD_UP=11) and the default parameter values.
REQ-029 The synchronizer, debounce and edge-detect logic SHALL be one sub-module, btn_debounce (ports clk, reset, btn_raw, level, press), instantiated twice.
REQ-030 Prescaler and FSM SHALL reside in updown_mode_ctrl itself.

Verification (bench parameters DEBOUNCE_CYCLES=4, TICK_DIV=5)
REQ-031 Reset high 3 cycles, then low, both buttons 0 -> mode=0, paused=0; cnt_en pulses every 5 cycles, first on the 5th edge after release.
REQ-032 btn_dir_raw high 3 cycles then low (bounce) -> mode stays 0, dir_changed never asserted.
REQ-033 btn_dir_raw high 10 cycles -> mode 0->1 exactly once, dir_changed high exactly 1 cycle at that edge, next cnt_en 5 cycles later.
REQ-034 Pause press, then 40 cycles -> paused=1, zero cnt_en; second pause press resumes with the tick interval continuing from the frozen prescaler value (gap <5 cycles).
REQ-035 Both buttons asserted on the same cycle for 10 cycles from RUN_DOWN -> HOLD_UP: mode=1, paused=1, one dir_changed pulse.
REQ-036 Reset asserted for 1 cycle while in HOLD_UP with btn_pause_raw held high -> RUN_DOWN, all outputs 0; no press registered until the button is released and pressed again.

Source files
------------

// File: rtl/updown_ctrl_pkg.sv
// Shared state encoding, default parameters and state helpers for the up/down mode controller.
// Encoding puts hold in bit 1 and direction in bit 0, so a press toggles exactly one bit.
package updown_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t RUN_DOWN  = 2'b00;
  localparam state_t RUN_UP    = 2'b01;
  localparam state_t HOLD_DOWN = 2'b10;
  localparam state_t HOLD_UP   = 2'b11;

  localparam logic [15:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [23:0] DEF_TICK_DIV        = 24'd5000000;

  function automatic state_t next_state(input state_t cur, input logic dir_press,
                                        input logic pause_press);
    return cur ^ {pause_press, dir_press};
  endfunction

  function automatic logic is_up(input state_t s);
    return s[0];
  endfunction

  function automatic logic is_hold(input state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, consecutive-cycle debounce, registered press pulse.
// Press fires with the debounced rise; disarmed after reset until the input is seen low.
module btn_debounce
  import updown_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic        press_q, press_d;
  logic        armed_q, armed_d;
  logic [1:0]  primed_q;
  logic [15:0] cnt_q, cnt_d;
  logic        flip;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    flip    = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        flip    = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
    press_d = flip & ~level_q & armed_q;
    // Synchronizer contents are only trusted two cycles after reset; a button held
    // through reset must be observed released before it can produce a press.
    armed_d = armed_q | (primed_q[1] & ~sync2_q & ~level_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      armed_q  <= 1'b0;
      primed_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      armed_q  <= armed_d;
      primed_q <= {primed_q[0], 1'b1};
      cnt_q    <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/updown_mode_ctrl.sv
// Direction/pause controller for a downstream up/down counter: FSM plus count-enable prescaler.
// State and all outputs update on the edge after a debounced press pulse.
module updown_mode_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [23:0] TICK_DIV        = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_dir_raw,
  input  logic btn_pause_raw,
  output logic mode,
  output logic cnt_en,
  output logic paused,
  output logic dir_changed
);

  logic        dir_press, pause_press;
  logic        dir_level_unused, pause_level_unused;
  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic        dir_chg, tick_d;
  logic        mode_q, mode_d;
  logic        paused_q, paused_d;
  logic        dchg_q, dchg_d;
  logic        cnt_en_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dir_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_dir_raw),
    .level   (dir_level_unused),
    .press   (dir_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_pause_raw),
    .level   (pause_level_unused),
    .press   (pause_press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN_DOWN;
      presc_q  <= '0;
      mode_q   <= 1'b0;
      paused_q <= 1'b0;
      dchg_q   <= 1'b0;
      cnt_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      paused_q <= paused_d;
      dchg_q   <= dchg_d;
      cnt_en_q <= tick_d;
    end
  end

  always_comb begin
    state_d = next_state(state_q, dir_press, pause_press);
  end

  // A direction change restarts the tick interval and swallows a coincident wrap.
  always_comb begin
    dir_chg = is_up(state_d) ^ is_up(state_q);
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (dir_chg) begin
      presc_d = '0;
    end else if (!is_hold(state_q)) begin
      if (presc_q == TICK_DIV - 24'd1) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 24'd1;
      end
    end
  end

  always_comb begin
    mode_d   = is_up(state_d);
    paused_d = is_hold(state_d);
    dchg_d   = dir_chg;
  end

  assign mode        = mode_q;
  assign cnt_en      = cnt_en_q;
  assign paused      = paused_q;
  assign dir_changed = dchg_q;

endmodule

// File: tb/tb_updown_mode_ctrl.sv
// Directed bench for updown_mode_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// A clean press held from just after edge 0 changes state on edge 7.
module tb_updown_mode_ctrl;

  logic clk;
  logic reset, btn_dir_raw, btn_pause_raw;
  logic mode, cnt_en, paused, dir_changed;

  int n_cmp = 0;
  int n_err = 0;

  int first, last, ticks, bad, dc, dc_at, m_at, mch, p_at, r_at, late;
  logic prev_mode;

  updown_mode_ctrl #(
    .DEBOUNCE_CYCLES (16'd4),
    .TICK_DIV        (24'd5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_dir_raw   (btn_dir_raw),
    .btn_pause_raw (btn_pause_raw),
    .mode          (mode),
    .cnt_en        (cnt_en),
    .paused        (paused),
    .dir_changed   (dir_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mode"}, {31'd0, mode}, 0);
    chk({tag, "_paused"}, {31'd0, paused}, 0);
    chk({tag, "_cnt_en"}, {31'd0, cnt_en}, 0);
    chk({tag, "_dir_changed"}, {31'd0, dir_changed}, 0);
  endtask

  initial begin
    reset = 1'b1;
    btn_dir_raw = 1'b0;
    btn_pause_raw = 1'b0;

    // Reset for 3 cycles, then free-run in RUN_DOWN
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    first = 0; last = 0; ticks = 0; bad = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (cnt_en) begin
        ticks++;
        if (first == 0) first = k;
        last = k;
      end
      if (mode || paused || dir_changed) bad++;
    end
    chk("run_first_tick", first, 5);
    chk("run_tick_count", ticks, 3);
    chk("run_last_tick", last, 15);
    chk("run_outputs_quiet", bad, 0);

    // Three-cycle bounce on dir: one short of debounce
    btn_dir_raw = 1'b1;
    bad = 0; dc = 0; ticks = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) btn_dir_raw = 1'b0;
      step();
      if (mode) bad++;
      if (dir_changed) dc++;
      if (cnt_en) ticks++;
    end
    chk("bounce_mode", bad, 0);
    chk("bounce_dir_changed", dc, 0);
    chk("bounce_ticks", ticks, 3);

    // Clean dir press: mode flips on edge 7, tick restarts from 0
    btn_dir_raw = 1'b1;
    prev_mode = mode;
    dc = 0; dc_at = 0; mch = 0; m_at = 0; first = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) btn_dir_raw = 1'b0;
      step();
      if (dir_changed) begin dc++; dc_at = k; end
      if (mode !== prev_mode) begin mch++; m_at = k; end
      prev_mode = mode;
      if (cnt_en && dc_at != 0 && k > dc_at && first == 0) first = k;
    end
    chk("dir_mode_changes", mch, 1);
    chk("dir_mode_edge", m_at, 7);
    chk("dir_pulse_count", dc, 1);
    chk("dir_pulse_edge", dc_at, 7);
    chk("dir_first_tick", first, 12);
    chk("dir_mode_final", {31'd0, mode}, 1);

    // Pause press: prescaler freezes at 1, no ticks while held
    step();
    btn_pause_raw = 1'b1;
    p_at = 0; late = 0; dc = 0; bad = 0;
    for (int k = 1; k <= 47; k++) begin
      if (k == 11) btn_pause_raw = 1'b0;
      step();
      if (paused && p_at == 0) p_at = k;
      if (k > 7 && cnt_en) late++;
      if (dir_changed) dc++;
      if (!mode) bad++;
    end
    chk("pause_edge", p_at, 7);
    chk("pause_no_ticks", late, 0);
    chk("pause_no_dir_changed", dc, 0);
    chk("pause_mode_kept", bad, 0);
    chk("pause_final", {31'd0, paused}, 1);

    // Resume: first tick 4 cycles after resume, from the frozen count
    btn_pause_raw = 1'b1;
    r_at = 0; first = 0; ticks = 0; dc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) btn_pause_raw = 1'b0;
      step();
      if (!paused && r_at == 0) r_at = k;
      if (cnt_en) begin
        ticks++;
        if (first == 0) first = k;
      end
      if (dir_changed) dc++;
    end
    chk("resume_edge", r_at, 7);
    chk("resume_first_tick", first, 11);
    chk("resume_tick_count", ticks, 2);
    chk("resume_no_dir_changed", dc, 0);

    // One-cycle reset, then both buttons together: RUN_DOWN -> HOLD_UP
    reset = 1'b1;
    step();
    chk_all_zero("reset2");
    reset = 1'b0;
    repeat (5) step();
    btn_dir_raw = 1'b1;
    btn_pause_raw = 1'b1;
    dc = 0; dc_at = 0; p_at = 0; late = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) begin
        btn_dir_raw = 1'b0;
        btn_pause_raw = 1'b0;
      end
      step();
      if (dir_changed) begin dc++; dc_at = k; end
      if (paused && p_at == 0) p_at = k;
      if (k >= 7 && cnt_en) late++;
    end
    chk("both_dir_pulse_count", dc, 1);
    chk("both_dir_pulse_edge", dc_at, 7);
    chk("both_pause_edge", p_at, 7);
    chk("both_no_ticks", late, 0);
    chk("both_mode", {31'd0, mode}, 1);
    chk("both_paused", {31'd0, paused}, 1);

    // Reset in HOLD_UP with pause held: held button must not register
    btn_pause_raw = 1'b1;
    reset = 1'b1;
    step();
    chk_all_zero("reset3");
    reset = 1'b0;
    bad = 0; dc = 0; ticks = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (paused) bad++;
      if (dir_changed) dc++;
      if (cnt_en) ticks++;
    end
    chk("held_no_pause", bad, 0);
    chk("held_no_dir_changed", dc, 0);
    chk("held_ticks", ticks, 6);
    chk("held_mode", {31'd0, mode}, 0);

    // Release, then press again: now accepted
    btn_pause_raw = 1'b0;
    repeat (15) step();
    chk("released_paused", {31'd0, paused}, 0);
    btn_pause_raw = 1'b1;
    p_at = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 11) btn_pause_raw = 1'b0;
      step();
      if (paused && p_at == 0) p_at = k;
    end
    chk("repress_pause_edge", p_at, 7);
    chk("repress_mode", {31'd0, mode}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
